irq_redirect_ctrl: RTL
======================

Name: irq_redirect_ctrl

Overview:
- Exception/interrupt controller on the control side of the program-counter register.
- Consumes the decoder's 3-bit next-PC select and the current PC/supervisor bit.
- Drives the final PCSrc into the PC register: 100 = illegal-op vector, 101 = interrupt vector.
- Latches external interrupt requests, applies a software mask, and emits an EPC write (return address into $k0) when a redirect is taken.

Parameters:
- NIRQ, 4, number of external interrupt lines (1..8).
- HOLD, 2, cycles after a redirect during which new interrupts are blocked while the PC supervisor bit settles.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- PCSrc_dec  input  3  next-PC select from the instruction decoder.
- IllOp  input  1  decoder flags the current instruction as illegal.
- PC  input  32  current PC.
- PC_31  input  1  registered supervisor bit; 1 = kernel mode.
- irq  input  NIRQ  level interrupt requests, rising-edge captured.
- reg_we  input  1  register write strobe.
- reg_addr  input  2  register select: 0 = MASK, 1 = PEND, 2 = CAUSE.
- reg_wdata  input  32  register write data.
- reg_rdata  output  32  register read data, combinational.
- PCSrc  output  3  final select to the PC register.
- epc_we  output  1  write $k0 this cycle.
- epc_data  output  32  return address.

Behaviour:
- Reset values: MASK = 0, PEND = 0, CAUSE = 0, edge-detect flops = 0, state IDLE, hold counter = 0.
- Combinational outputs during reset: epc_we = 0; PCSrc = PCSrc_dec.
- Edge capture:
  - irq_q <= irq each cycle.
  - PEND[i] <= 1 when irq[i] & ~irq_q[i].
  - A software write-1-to-clear to PEND (reg_addr = 1) clears the written bits.
  - A new edge in the same cycle as a clear of that bit wins: the bit stays 1.
- MASK write: reg_addr = 0 loads MASK[NIRQ-1:0]. CAUSE is read-only; writes are ignored.
- Read mux: zero-extended MASK, PEND, or CAUSE. Address 3 reads 0.
- Eligible interrupt: eligible = PEND & MASK, gated by PC_31 == 0, state == IDLE, and hold counter == 0.
- Priority: IllOp > interrupt > decoder select. Among interrupts, the lowest index wins.
- FSM states: IDLE, HOLD.
- IDLE, IllOp = 1 (taken regardless of PC_31):
  - PCSrc = 100, epc_we = 1, epc_data = {PC[31], PC[30:0] + 4}.
  - CAUSE <= {1'b1, 31'd0}.
  - Go to HOLD and load counter = HOLD.
- IDLE, eligible != 0:
  - PCSrc = 101, epc_we = 1, epc_data = PC. The interrupted instruction is not executed and is re-run on return.
  - CAUSE <= index of the winning line.
  - That PEND bit is not cleared by hardware; the handler clears it.
  - Go to HOLD.
- IDLE, otherwise: PCSrc = PCSrc_dec, epc_we = 0.
- HOLD:
  - PCSrc = PCSrc_dec unless IllOp (IllOp still redirects, reloads the counter, and updates CAUSE).
  - Counter decrements each cycle; go to IDLE when it reaches 1.
  - HOLD = 0 is legal: skip the HOLD state.
- Edges arriving during HOLD or kernel mode are latched in PEND and serviced once back in IDLE in user mode.
- Arithmetic: epc_data addition wraps within bits 30:0; bit 31 is preserved.
- Asynchronous reset mid-HOLD returns to IDLE immediately.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined:
  - irq passes through a two-flop synchronizer before edge capture, adding 2 cycles of capture latency.
  - Synchronizer flops reset to 0.
- Undefined: irq is sampled directly; an edge sets PEND one cycle after it appears.

Test Plan:
- Reset, then read all registers -> reg_rdata = 0 for addresses 0..3; PCSrc follows PCSrc_dec = 010.
- MASK = 0x3, PC = 0x00400010, PC_31 = 0, irq[1] rises -> next cycle PEND = 0x2; that cycle PCSrc = 101, epc_data = 0x00400010, epc_we = 1, CAUSE = 1; then HOLD for 2 cycles with PCSrc = PCSrc_dec.
- irq[0] and irq[2] rise together, MASK = 0x5 -> line 0 serviced first (CAUSE = 0). After software writes PEND = 0x1 and returns to user mode, line 2 is serviced (CAUSE = 2).
- IllOp = 1 with PC = 0x80000020, PC_31 = 1, eligible IRQ pending -> PCSrc = 100, epc_data = 0x80000024, CAUSE = 0x80000000; no interrupt taken.
- PC_31 = 1 with PEND & MASK != 0 -> PCSrc = PCSrc_dec, no epc_we; after PC_31 drops to 0, redirect occurs in the first IDLE cycle.
- Write-1-to-clear on PEND[3] in the same cycle as an irq[3] edge -> PEND[3] remains 1; assert reset during HOLD -> state IDLE and all registers 0.

Source files
------------

// File: rtl/irq_redirect_ctrl.sv
// rtl/irq_redirect_ctrl.sv - PC redirect controller for illegal-op and interrupt vectors with EPC write
// Optional IRQ_SYNC_EN: two-flop synchronizer on irq ahead of edge capture.
module irq_redirect_ctrl #(
    parameter int NIRQ = 4,
    parameter int HOLD = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      PCSrc_dec,
    input  logic            IllOp,
    input  logic [31:0]     PC,
    input  logic            PC_31,
    input  logic [NIRQ-1:0] irq,
    input  logic            reg_we,
    input  logic [1:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic [2:0]      PCSrc,
    output logic            epc_we,
    output logic [31:0]     epc_data
);

    localparam int CW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NIRQ-1:0] irq_s;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] pend;
    logic [31:0]     cause;
    logic [NIRQ-1:0] edge_det;
    logic [NIRQ-1:0] pend_clr;
    logic [NIRQ-1:0] eligible;
    logic [2:0]      win_idx;
    logic            take_ill;
    logic            take_irq;
    logic            redirect;
    logic            unused_ok;

    assign unused_ok = &{1'b0, reg_wdata[31:NIRQ]};

`ifdef IRQ_SYNC_EN
    logic [NIRQ-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq;
`endif

    assign edge_det = irq_s & ~irq_q;
    assign pend_clr = (reg_we && reg_addr == 2'd1) ? reg_wdata[NIRQ-1:0] : '0;

    // Interrupts only fire from a settled user-mode IDLE; IllOp bypasses this gate.
    assign eligible = (pend & mask) &
                      {NIRQ{~PC_31 && state == S_IDLE && cnt == '0}};

    always_comb begin
        win_idx = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    assign take_ill = IllOp;
    assign take_irq = ~IllOp && (|eligible);
    assign redirect = take_ill || take_irq;

    always_comb begin
        PCSrc    = PCSrc_dec;
        epc_we   = 1'b0;
        epc_data = PC;
        if (take_ill) begin
            epc_data = {PC[31], PC[30:0] + 31'd4};
        end
        if (!reset) begin
            if (take_ill) begin
                PCSrc  = 3'b100;
                epc_we = 1'b1;
            end else if (take_irq) begin
                PCSrc  = 3'b101;
                epc_we = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (redirect) begin
            if (HOLD == 0) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = S_HOLD;
                cnt_d   = HOLD_LD;
            end
        end else if (state == S_HOLD) begin
            if (cnt <= CW'(1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            irq_q <= '0;
            mask  <= '0;
            pend  <= '0;
            cause <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            irq_q <= irq_s;
            // A fresh edge wins over a same-cycle software clear.
            pend  <= (pend & ~pend_clr) | edge_det;
            if (reg_we && reg_addr == 2'd0) begin
                mask <= reg_wdata[NIRQ-1:0];
            end
            if (take_ill) begin
                cause <= {1'b1, 31'd0};
            end else if (take_irq) begin
                cause <= {29'd0, win_idx};
            end
        end
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            2'd0:    reg_rdata = {{(32-NIRQ){1'b0}}, mask};
            2'd1:    reg_rdata = {{(32-NIRQ){1'b0}}, pend};
            2'd2:    reg_rdata = cause;
            default: reg_rdata = 32'd0;
        endcase
    end

endmodule
